// File: rtl/hwpe_stream_package.sv
// Shared HWPE stream declarations.
// - copy_src_state_e           : state of the copy-source stability checker
// - COPY_SRC_CNT_WIDTH_DEFAULT : default width of the copy-source fault counter
package hwpe_stream_package;

   typedef enum logic {
      COPY_SRC_IDLE,
      COPY_SRC_STALLED
   } copy_src_state_e;

   localparam int unsigned COPY_SRC_CNT_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// HWPE valid/ready stream bundle.
// Signals: valid, ready, data[DATA_WIDTH], strb[STRB_WIDTH].
// Modports:
// - source  : drives valid/data/strb, receives ready
// - sink    : receives valid/data/strb, drives ready
// - monitor : observes every signal, drives nothing
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [STRB_WIDTH-1:0] strb;

   modport source (
      output valid, data, strb,
      input  ready
   );

   modport sink (
      input  valid, data, strb,
      output ready
   );

   modport monitor (
      input valid, ready, data, strb
   );

endinterface

// File: rtl/hwpe_stream_stability_checker.sv
// Producer stability checker.
// Watches one valid/ready stream and flags any cycle in which a stalled beat
// (valid & !ready) is withdrawn or has its data/strb changed before the handshake.
// Ports:
// - clk_i, rst_ni : clock, asynchronous active-low reset
// - clear_i       : synchronous return to COPY_SRC_IDLE
// - valid_i, ready_i, data_i, strb_i : observed stream
// - violation_o   : combinational, high in the offending cycle
module hwpe_stream_stability_checker
   import hwpe_stream_package::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  valid_i,
   input  logic                  ready_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [STRB_WIDTH-1:0] strb_i,
   output logic                  violation_o
);

   copy_src_state_e       state_q, state_d;
   logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;
   logic [STRB_WIDTH-1:0] cap_strb_q, cap_strb_d;

   always_comb begin
      state_d     = state_q;
      cap_data_d  = cap_data_q;
      cap_strb_d  = cap_strb_q;
      violation_o = 1'b0;

      unique case (state_q)
         COPY_SRC_IDLE: begin
            if (valid_i && !ready_i) begin
               state_d    = COPY_SRC_STALLED;
               cap_data_d = data_i;
               cap_strb_d = strb_i;
            end
         end
         COPY_SRC_STALLED: begin
            if (valid_i && ready_i) begin
               state_d = COPY_SRC_IDLE;
            end else if (!valid_i) begin
               violation_o = 1'b1;
               state_d     = COPY_SRC_IDLE;
            end else if ((data_i != cap_data_q) || (strb_i != cap_strb_q)) begin
               // Recapture so a single change is reported once, not every cycle.
               violation_o = 1'b1;
               cap_data_d  = data_i;
               cap_strb_d  = strb_i;
            end
         end
         default: state_d = COPY_SRC_IDLE;
      endcase

      // A stall still in progress gets recaptured from IDLE next cycle.
      if (clear_i) begin
         state_d = COPY_SRC_IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= COPY_SRC_IDLE;
         cap_data_q <= '0;
         cap_strb_q <= '0;
      end else begin
         state_q    <= state_d;
         cap_data_q <= cap_data_d;
         cap_strb_q <= cap_strb_d;
      end
   end

endmodule

// File: rtl/hwpe_stream_copy_source.sv
// Transmit side of the HWPE stream copy-network fault detection.
// Forwards the monitored normal stream onto the copy stream with zero latency,
// compares copy-side ready against normal-side ready, and optionally checks
// producer stability during stalls.
// Ports:
// - clk_i, rst_ni    : clock, asynchronous active-low reset
// - normal_i         : normal stream (monitor only, never driven)
// - copy_o           : copy stream into the duplicated network
// - clear_i          : synchronous clear of sticky flag, counter and checker
// - fault_detected_o : registered ready-mismatch fault
// - protocol_error_o : registered stability-violation pulse
// - fault_sticky_o   : set on any fault until clear_i
// - fault_count_o    : saturating count of faulty cycles
module hwpe_stream_copy_source
   import hwpe_stream_package::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned CNT_WIDTH      = COPY_SRC_CNT_WIDTH_DEFAULT,
   parameter bit          PROTOCOL_CHECK = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   hwpe_stream_intf_stream.monitor normal_i,
   hwpe_stream_intf_stream.source  copy_o,
   input  logic                    clear_i,
   output logic                    fault_detected_o,
   output logic                    protocol_error_o,
   output logic                    fault_sticky_o,
   output logic [CNT_WIDTH-1:0]    fault_count_o
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                 mismatch_d;
   logic                 violation;
   logic                 fault_ev;
   logic                 fault_detected_q;
   logic                 protocol_error_q;
   logic                 fault_sticky_q, fault_sticky_d;
   logic [CNT_WIDTH-1:0] fault_count_q, fault_count_d;

   assign copy_o.valid = normal_i.valid;
   assign copy_o.data  = normal_i.data;
   assign copy_o.strb  = normal_i.strb;

   // Checked every cycle: the duplicated network must mirror backpressure even when idle.
   assign mismatch_d = (copy_o.ready != normal_i.ready);

   if (PROTOCOL_CHECK) begin : gen_checker
      hwpe_stream_stability_checker #(
         .DATA_WIDTH (DATA_WIDTH),
         .STRB_WIDTH (STRB_WIDTH)
      ) i_stability_checker (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .clear_i     (clear_i),
         .valid_i     (normal_i.valid),
         .ready_i     (normal_i.ready),
         .data_i      (normal_i.data),
         .strb_i      (normal_i.strb),
         .violation_o (violation)
      );
   end else begin : gen_no_checker
      assign violation = 1'b0;
   end

   // Both faults in one cycle count once.
   assign fault_ev = mismatch_d | violation;

   always_comb begin
      fault_sticky_d = fault_sticky_q;
      if (fault_ev) begin
         fault_sticky_d = 1'b1;
      end else if (clear_i) begin
         fault_sticky_d = 1'b0;
      end
   end

   always_comb begin
      fault_count_d = fault_count_q;
      if (clear_i) begin
         fault_count_d = fault_ev ? CNT_WIDTH'(1) : '0;
      end else if (fault_ev && (fault_count_q != '1)) begin
         fault_count_d = fault_count_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fault_detected_q <= 1'b0;
         protocol_error_q <= 1'b0;
         fault_sticky_q   <= 1'b0;
         fault_count_q    <= '0;
      end else begin
         fault_detected_q <= mismatch_d;
         protocol_error_q <= violation;
         fault_sticky_q   <= fault_sticky_d;
         fault_count_q    <= fault_count_d;
      end
   end

   assign fault_detected_o = fault_detected_q;
   assign protocol_error_o = protocol_error_q;
   assign fault_sticky_o   = fault_sticky_q;
   assign fault_count_o    = fault_count_q;

endmodule

// File: tb/tb_hwpe_stream_copy_source.sv
// Self-checking bench for hwpe_stream_copy_source: directed steps, with the
// registered outputs predicted by a small reference model and queued per cycle.
module tb_hwpe_stream_copy_source;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 8;

   typedef struct packed {
      logic          fd;
      logic          pe;
      logic          st;
      logic [CW-1:0] cnt;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          clear;
   logic          fault_detected;
   logic          protocol_error;
   logic          fault_sticky;
   logic [CW-1:0] fault_count;

   int n_tests;
   int n_fail;

   exp_t exp_q[$];

   // Reference model state
   logic          m_stalled;
   logic [DW-1:0] m_cap_data;
   logic [3:0]    m_cap_strb;
   logic          m_sticky;
   logic [CW-1:0] m_count;

   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) normal ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) copy ();

   hwpe_stream_copy_source #(
      .DATA_WIDTH     (DW),
      .CNT_WIDTH      (CW),
      .PROTOCOL_CHECK (1'b1)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .normal_i         (normal),
      .copy_o           (copy),
      .clear_i          (clear),
      .fault_detected_o (fault_detected),
      .protocol_error_o (protocol_error),
      .fault_sticky_o   (fault_sticky),
      .fault_count_o    (fault_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_stalled  = 1'b0;
      m_cap_data = '0;
      m_cap_strb = '0;
      m_sticky   = 1'b0;
      m_count    = '0;
   endtask

   // One clock cycle: drive at negedge, check forwarding, predict, compare after posedge.
   task automatic step(input logic v, input logic rn, input logic rc,
                       input logic [DW-1:0] d, input logic [3:0] s, input logic clr);
      logic mm;
      logic viol;
      logic ev;
      exp_t e;
      @(negedge clk);
      normal.valid = v;
      normal.ready = rn;
      normal.data  = d;
      normal.strb  = s;
      copy.ready   = rc;
      clear        = clr;
      #1;
      check("fwd_valid", 32'(copy.valid), 32'(v));
      check("fwd_data", copy.data, d);
      check("fwd_strb", 32'(copy.strb), 32'(s));

      mm   = (rc != rn);
      viol = 1'b0;
      if (!m_stalled) begin
         if (v && !rn) begin
            m_stalled  = 1'b1;
            m_cap_data = d;
            m_cap_strb = s;
         end
      end else begin
         if (v && rn) begin
            m_stalled = 1'b0;
         end else if (!v) begin
            viol      = 1'b1;
            m_stalled = 1'b0;
         end else if (d != m_cap_data || s != m_cap_strb) begin
            viol       = 1'b1;
            m_cap_data = d;
            m_cap_strb = s;
         end
      end
      if (clr) m_stalled = 1'b0;
      ev = mm | viol;
      if (ev) m_sticky = 1'b1;
      else if (clr) m_sticky = 1'b0;
      if (clr) m_count = ev ? CW'(1) : '0;
      else if (ev && m_count != {CW{1'b1}}) m_count = m_count + CW'(1);
      e.fd  = mm;
      e.pe  = viol;
      e.st  = m_sticky;
      e.cnt = m_count;
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("fault_detected", 32'(fault_detected), 32'(e.fd));
      check("protocol_error", 32'(protocol_error), 32'(e.pe));
      check("fault_sticky", 32'(fault_sticky), 32'(e.st));
      check("fault_count", 32'(fault_count), 32'(e.cnt));
   endtask

   initial begin
      int beat;
      int guard;
      logic r;
      n_tests      = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      clear        = 1'b0;
      normal.valid = 1'b0;
      normal.ready = 1'b0;
      normal.data  = '0;
      normal.strb  = '0;
      copy.ready   = 1'b0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_fault_detected", 32'(fault_detected), 32'd0);
      check("rst_protocol_error", 32'(protocol_error), 32'd0);
      check("rst_fault_sticky", 32'(fault_sticky), 32'd0);
      check("rst_fault_count", 32'(fault_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: 16 beats with random stalls, readies agree
      beat  = 0;
      guard = 0;
      while (beat < 16 && guard < 200) begin
         r = ($urandom_range(0, 2) != 0);
         step(1'b1, r, r, DW'(beat), 4'hF, 1'b0);
         if (r) beat++;
         guard++;
      end
      check("t1_beats", 32'(beat), 32'd16);
      step(1'b0, 1'b1, 1'b1, '0, 4'h0, 1'b0);
      check("t1_sticky", 32'(fault_sticky), 32'd0);
      check("t1_count", 32'(fault_count), 32'd0);

      // 2: single-cycle ready mismatch
      step(1'b1, 1'b1, 1'b0, 32'h11, 4'hF, 1'b0);
      check("t2_fd_after", 32'(fault_detected), 32'd1);
      check("t2_sticky_after", 32'(fault_sticky), 32'd1);
      step(1'b0, 1'b1, 1'b1, '0, 4'h0, 1'b0);
      check("t2_fd_cleared", 32'(fault_detected), 32'd0);
      check("t2_count", 32'(fault_count), 32'd1);
      check("t2_sticky_held", 32'(fault_sticky), 32'd1);

      // 3: data change during a stall flags once
      step(1'b0, 1'b0, 1'b0, '0, 4'h0, 1'b1);
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 4'hF, 1'b0);
      check("t3_no_err_stable", 32'(protocol_error), 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'h5A5A5A5A, 4'hF, 1'b0);
      check("t3_pe_pulse", 32'(protocol_error), 32'd1);
      check("t3_count", 32'(fault_count), 32'd1);
      repeat (2) step(1'b1, 1'b0, 1'b0, 32'h5A5A5A5A, 4'hF, 1'b0);
      check("t3_no_repeat", 32'(protocol_error), 32'd0);
      step(1'b1, 1'b1, 1'b1, 32'h5A5A5A5A, 4'hF, 1'b0);
      check("t3_count_final", 32'(fault_count), 32'd1);

      // 4: valid dropped during a stall
      step(1'b0, 1'b0, 1'b0, '0, 4'h0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'h77, 4'hF, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h77, 4'hF, 1'b0);
      check("t4_pe_drop", 32'(protocol_error), 32'd1);
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'h88, 4'h3, 1'b0);
      step(1'b1, 1'b1, 1'b1, 32'h88, 4'h3, 1'b0);
      check("t4_pe_stable", 32'(protocol_error), 32'd0);
      check("t4_count", 32'(fault_count), 32'd1);

      // 5: saturation and clear interaction
      step(1'b0, 1'b0, 1'b0, '0, 4'h0, 1'b1);
      for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, '0, 4'h0, 1'b0);
      check("t5_saturated", 32'(fault_count), 32'd255);
      step(1'b0, 1'b1, 1'b0, '0, 4'h0, 1'b1);
      check("t5_clr_fault_count", 32'(fault_count), 32'd1);
      check("t5_clr_fault_sticky", 32'(fault_sticky), 32'd1);
      step(1'b0, 1'b1, 1'b1, '0, 4'h0, 1'b1);
      check("t5_clr_count", 32'(fault_count), 32'd0);
      check("t5_clr_sticky", 32'(fault_sticky), 32'd0);

      // 6: asynchronous reset mid-stall
      repeat (5) step(1'b0, 1'b0, 1'b1, '0, 4'h0, 1'b0);
      check("t6_pre_count", 32'(fault_count), 32'd5);
      step(1'b1, 1'b0, 1'b0, 32'hCAFE, 4'hF, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'hCAFE, 4'hF, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_fd", 32'(fault_detected), 32'd0);
      check("t6_rst_pe", 32'(protocol_error), 32'd0);
      check("t6_rst_sticky", 32'(fault_sticky), 32'd0);
      check("t6_rst_count", 32'(fault_count), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'hCAFE, 4'hF, 1'b0);
      check("t6_no_err", 32'(protocol_error), 32'd0);
      step(1'b1, 1'b1, 1'b1, 32'hCAFE, 4'hF, 1'b0);
      check("t6_final_count", 32'(fault_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
